// File: rtl/spi_frame_host.sv
// spi_frame_host: streams one framebuffer (WORDS x 32-bit) out over a mode-0
// SPI link inside a single chip-select burst.
//
// Handshake: start is a one-cycle request that is accepted only while the
// block is idle (busy=0, done=0). There is no separate ready; busy is the
// sole backpressure indication and done marks the first cycle in which the
// block is idle again (a start in that cycle is ignored). The RAM side is a
// plain read strobe: mem_rd/mem_addr for one cycle, mem_data valid the next.
//
// Assumes CS_SETUP >= 2 so word 0 arrives before setup ends, WORDS >= 2,
// and CLK_DIV/CS_* below 65536.
module spi_frame_host #(
    parameter int CLK_DIV  = 2,
    parameter int WORDS    = 2048,
    parameter int ADDR_W   = 11,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    output logic              spi_clk,
    output logic              spi_mosi,
    output logic              spi_cs,
    output logic [ADDR_W-1:0] word_idx,
    output logic [2:0]        state_dbg
);

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);
    // Prefetch of word_idx+2 is only issued while word_idx < WORDS-2.
    localparam logic [ADDR_W-1:0] PF_LIMIT = ADDR_W'(WORDS - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] cnt;        // cycles spent in the current state
    logic [15:0] div_cnt;    // cycles spent in the current spi_clk half
    logic [4:0]  bit_cnt;    // bit of the current word, wraps 31 -> 0
    logic [31:0] shift_reg;
    logic [31:0] hold_reg;   // prefetched next word
    logic        rd_q;       // mem_data is valid this cycle

    logic half_end;
    logic fall_evt;
    logic last_bit;
    logic last_word;
    logic frame_end;
    logic setup_end;
    logic hold_end;
    logic gap_end;

    assign half_end  = (state == S_SHIFT) && (div_cnt == DIV_LAST);
    assign fall_evt  = half_end && spi_clk;
    assign last_bit  = (bit_cnt == 5'd31);
    assign last_word = (word_idx == LAST_IDX);
    assign frame_end = fall_evt && last_bit && last_word;
    assign setup_end = (state == S_SETUP) && (cnt == SETUP_LAST);
    assign hold_end  = (state == S_HOLD) && (cnt == HOLD_LAST);
    assign gap_end   = (state == S_GAP) && (cnt == GAP_LAST);

    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    // Next-state logic: one pass IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> DONE.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start)     state_n = S_SETUP;
            S_SETUP: if (setup_end) state_n = S_SHIFT;
            S_SHIFT: if (frame_end) state_n = S_HOLD;
            S_HOLD:  if (hold_end)  state_n = S_GAP;
            S_GAP:   if (gap_end)   state_n = S_DONE;
            S_DONE:                 state_n = S_IDLE;
            default:                state_n = S_IDLE;
        endcase
    end

    // Output decode: chip select, busy/done and the data line follow the state.
    always_comb begin
        spi_cs   = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        spi_mosi = 1'b0;
        case (state)
            S_SETUP, S_SHIFT: begin
                spi_cs   = 1'b0;
                busy     = 1'b1;
                spi_mosi = shift_reg[31];
            end
            S_HOLD: begin
                spi_cs = 1'b0;
                busy   = 1'b1;
            end
            S_GAP:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: RAM reads, shift/holding registers, spi_clk divider and counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            word_idx  <= '0;
            spi_clk   <= 1'b0;
            cnt       <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            hold_reg  <= '0;
            rd_q      <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            rd_q   <= mem_rd;

            if (state_n != state) cnt <= '0;
            else                  cnt <= cnt + 16'd1;

            if ((state == S_SHIFT) && rd_q) hold_reg <= mem_data;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        mem_rd    <= 1'b1;
                        mem_addr  <= '0;
                        word_idx  <= '0;
                        bit_cnt   <= '0;
                        div_cnt   <= '0;
                        spi_clk   <= 1'b0;
                        shift_reg <= '0;
                    end
                end
                S_SETUP: begin
                    // Word 0 read was issued on entry; data is valid at cnt==1.
                    if (cnt == 16'd1) shift_reg <= mem_data;
                    if (setup_end) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= ADDR_W'(1);
                        div_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        spi_clk <= ~spi_clk;
                        if (spi_clk) begin
                            // Falling edge: advance the data line.
                            if (last_bit) begin
                                bit_cnt <= '0;
                                if (!last_word) begin
                                    shift_reg <= hold_reg;
                                    word_idx  <= word_idx + ADDR_W'(1);
                                    if (word_idx < PF_LIMIT) begin
                                        mem_rd   <= 1'b1;
                                        mem_addr <= word_idx + ADDR_W'(2);
                                    end
                                end
                            end else begin
                                shift_reg <= {shift_reg[30:0], 1'b0};
                                bit_cnt   <= bit_cnt + 5'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_host.sv
// Bench for spi_frame_host: two instances (4 words / CLK_DIV=2 and
// 64 words / CLK_DIV=1), each with a latency-1 RAM model and an SPI
// receiver model that rebuilds words from spi_mosi on spi_clk rising edges.
// Expected values come from the frame rules: word n = RAM[n], 32 rises per
// word, cs low for setup + 64*words*div + hold, gap before done, reads 0..N-1.
module tb_spi_frame_host;

  localparam int SETUP = 4;
  localparam int HOLD  = 4;
  localparam int GAP   = 8;
  localparam int A_DIV = 2;
  localparam int A_WORDS = 4;
  localparam int A_AW = 2;
  localparam int B_DIV = 1;
  localparam int B_WORDS = 64;
  localparam int B_AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic a_busy, a_done, a_mem_rd, a_spi_clk, a_spi_mosi, a_spi_cs;
  logic [A_AW-1:0] a_mem_addr, a_word_idx;
  logic [31:0] a_mem_data = '0;
  logic [2:0] a_state;

  logic b_busy, b_done, b_mem_rd, b_spi_clk, b_spi_mosi, b_spi_cs;
  logic [B_AW-1:0] b_mem_addr, b_word_idx;
  logic [31:0] b_mem_data = '0;
  logic [2:0] b_state;

  spi_frame_host #(.CLK_DIV(A_DIV), .WORDS(A_WORDS), .ADDR_W(A_AW),
                   .CS_SETUP(SETUP), .CS_HOLD(HOLD), .CS_GAP(GAP)) dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .busy(a_busy), .done(a_done),
    .mem_rd(a_mem_rd), .mem_addr(a_mem_addr), .mem_data(a_mem_data),
    .spi_clk(a_spi_clk), .spi_mosi(a_spi_mosi), .spi_cs(a_spi_cs),
    .word_idx(a_word_idx), .state_dbg(a_state)
  );

  spi_frame_host #(.CLK_DIV(B_DIV), .WORDS(B_WORDS), .ADDR_W(B_AW),
                   .CS_SETUP(SETUP), .CS_HOLD(HOLD), .CS_GAP(GAP)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .busy(b_busy), .done(b_done),
    .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
    .spi_clk(b_spi_clk), .spi_mosi(b_spi_mosi), .spi_cs(b_spi_cs),
    .word_idx(b_word_idx), .state_dbg(b_state)
  );

  // RAM models, read latency 1
  logic [31:0] ram_a [A_WORDS];
  logic [31:0] ram_b [B_WORDS];
  always @(posedge clk) if (a_mem_rd) a_mem_data <= ram_a[a_mem_addr];
  always @(posedge clk) if (b_mem_rd) b_mem_data <= ram_b[b_mem_addr];

  int total = 0;
  int bad = 0;

  // ---------------- receiver / timing monitor, instance A ----------------
  int a_cyc = 0, a_frames = 0, a_rises = 0, a_cs_low = 0, a_cs_low_last = 0;
  int a_first_rise = -1, a_last_rise = 0, a_max_per = 0, a_gap = 0, a_gap_last = 0;
  int a_done_cnt = 0, a_done_cyc = 0, a_fall_cyc = 0, a_bits = 0, a_busy_len = 0;
  logic a_pclk = 1'b0, a_pcs = 1'b1;
  logic [31:0] a_sh = '0;
  logic [31:0] a_words[$];
  int a_rd_q[$];

  always @(negedge clk) begin
    a_cyc++;
    if (!a_spi_cs && a_pcs) begin
      a_frames++; a_words.delete(); a_rd_q.delete();
      a_rises = 0; a_cs_low = 0; a_first_rise = -1; a_bits = 0;
      a_max_per = 0; a_fall_cyc = a_cyc; a_busy_len = 0;
    end
    if (!a_spi_cs) a_cs_low++;
    if (a_busy) a_busy_len++;
    if (a_spi_cs && !a_pcs) begin a_cs_low_last = a_cs_low; a_gap = 0; end
    if (a_spi_cs && !a_done) a_gap++;
    if (a_spi_clk && !a_pclk) begin
      if (a_rises == 0) a_first_rise = a_cyc - a_fall_cyc;
      else if (a_cyc - a_last_rise > a_max_per) a_max_per = a_cyc - a_last_rise;
      a_last_rise = a_cyc;
      a_rises++;
      a_sh = {a_sh[30:0], a_spi_mosi};
      a_bits++;
      if (a_bits == 32) begin a_words.push_back(a_sh); a_bits = 0; end
    end
    if (a_mem_rd) a_rd_q.push_back(int'(a_mem_addr));
    if (a_done) begin a_done_cnt++; a_gap_last = a_gap; a_done_cyc = a_cyc; end
    a_pclk = a_spi_clk; a_pcs = a_spi_cs;
  end

  // ---------------- receiver / timing monitor, instance B ----------------
  int b_cyc = 0, b_frames = 0, b_rises = 0, b_cs_low = 0, b_cs_low_last = 0;
  int b_first_rise = -1, b_last_rise = 0, b_max_per = 0, b_gap = 0, b_gap_last = 0;
  int b_done_cnt = 0, b_fall_cyc = 0, b_bits = 0, b_busy_len = 0, b_tog = 0;
  logic b_pclk = 1'b0, b_pcs = 1'b1, b_pmosi = 1'b0;
  logic [31:0] b_sh = '0;
  logic [31:0] b_words[$];
  int b_rd_q[$];

  always @(negedge clk) begin
    b_cyc++;
    if (!b_spi_cs && b_pcs) begin
      b_frames++; b_words.delete(); b_rd_q.delete();
      b_rises = 0; b_cs_low = 0; b_first_rise = -1; b_bits = 0;
      b_max_per = 0; b_fall_cyc = b_cyc; b_busy_len = 0; b_tog = 0;
    end
    if (!b_spi_cs) b_cs_low++;
    if (b_busy) b_busy_len++;
    if (b_spi_cs && !b_pcs) begin b_cs_low_last = b_cs_low; b_gap = 0; end
    if (b_spi_cs && !b_done) b_gap++;
    if (b_spi_clk && !b_pclk) begin
      if (b_rises == 0) b_first_rise = b_cyc - b_fall_cyc;
      else if (b_cyc - b_last_rise > b_max_per) b_max_per = b_cyc - b_last_rise;
      if (b_rises > 0 && b_rises < 32 && b_spi_mosi != b_pmosi) b_tog++;
      b_pmosi = b_spi_mosi;
      b_last_rise = b_cyc;
      b_rises++;
      b_sh = {b_sh[30:0], b_spi_mosi};
      b_bits++;
      if (b_bits == 32) begin b_words.push_back(b_sh); b_bits = 0; end
    end
    if (b_mem_rd) b_rd_q.push_back(int'(b_mem_addr));
    if (b_done) begin b_done_cnt++; b_gap_last = b_gap; end
    b_pclk = b_spi_clk; b_pcs = b_spi_cs;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
  endtask

  task automatic wait_a_done(input int budget);
    int n = 0;
    while (a_done !== 1'b1 && n < budget) begin tick(1); n++; end
    check("a_done_seen", a_done, 1'b1);
  endtask

  task automatic wait_b_done(input int budget);
    int n = 0;
    while (b_done !== 1'b1 && n < budget) begin tick(1); n++; end
    check("b_done_seen", b_done, 1'b1);
  endtask

  // Whole-frame expectations for instance A, derived from the frame rules.
  task automatic check_frame_a(input string tag);
    check({tag, "_nwords"}, a_words.size(), A_WORDS);
    for (int i = 0; i < A_WORDS; i++)
      check($sformatf("%s_word%0d", tag, i), (i < a_words.size()) ? a_words[i] : 32'hx, ram_a[i]);
    check({tag, "_rises"}, a_rises, 32 * A_WORDS);
    check({tag, "_cs_low"}, a_cs_low_last, SETUP + 64 * A_WORDS * A_DIV + HOLD);
    check({tag, "_gap"}, a_gap_last, GAP);
    check({tag, "_first_rise"}, a_first_rise, SETUP + A_DIV);
    check({tag, "_max_period"}, a_max_per, 2 * A_DIV);
    check({tag, "_busy_len"}, a_busy_len, SETUP + 64 * A_WORDS * A_DIV + HOLD + GAP);
    check({tag, "_busy_at_done"}, a_busy, 1'b0);
    check({tag, "_nreads"}, a_rd_q.size(), A_WORDS);
    for (int i = 0; i < A_WORDS; i++)
      check($sformatf("%s_rdaddr%0d", tag, i), (i < a_rd_q.size()) ? a_rd_q[i] : -1, i);
  endtask

  task automatic check_frame_b(input string tag);
    int exp_tog;
    logic [31:0] w;
    w = ram_b[0];
    exp_tog = $countones((w ^ (w >> 1)) & 32'h7FFF_FFFF);
    check({tag, "_nwords"}, b_words.size(), B_WORDS);
    for (int i = 0; i < B_WORDS; i++)
      check($sformatf("%s_word%0d", tag, i), (i < b_words.size()) ? b_words[i] : 32'hx, ram_b[i]);
    check({tag, "_rises"}, b_rises, 32 * B_WORDS);
    check({tag, "_cs_low"}, b_cs_low_last, SETUP + 64 * B_WORDS * B_DIV + HOLD);
    check({tag, "_gap"}, b_gap_last, GAP);
    check({tag, "_first_rise"}, b_first_rise, SETUP + B_DIV);
    check({tag, "_max_period"}, b_max_per, 2 * B_DIV);
    check({tag, "_busy_len"}, b_busy_len, SETUP + 64 * B_WORDS * B_DIV + HOLD + GAP);
    check({tag, "_word0_toggles"}, b_tog, exp_tog);
    check({tag, "_nreads"}, b_rd_q.size(), B_WORDS);
    for (int i = 0; i < B_WORDS; i++)
      check($sformatf("%s_rdaddr%0d", tag, i), (i < b_rd_q.size()) ? b_rd_q[i] : -1, i);
  endtask

  initial begin
    int exp_done_a;
    int f0;
    int d0;
    int n;
    exp_done_a = 0;

    // ---- reset values ----
    resetn = 1'b0;
    tick(4);
    check("rst_a_cs", a_spi_cs, 1'b1);
    check("rst_a_clk", a_spi_clk, 1'b0);
    check("rst_a_mosi", a_spi_mosi, 1'b0);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_a_done", a_done, 1'b0);
    check("rst_a_rd", a_mem_rd, 1'b0);
    check("rst_a_addr", a_mem_addr, 0);
    check("rst_a_widx", a_word_idx, 0);
    check("rst_b_cs", b_spi_cs, 1'b1);
    check("rst_b_busy", b_busy, 1'b0);
    resetn = 1'b1;
    tick(2);

    // ---- directed frame with fixed RAM contents ----
    ram_a[0] = 32'h8000_0001; ram_a[1] = 32'h1234_5678;
    ram_a[2] = 32'hFFFF_0000; ram_a[3] = 32'h0000_FFFF;
    pulse_a();
    tick(1);
    check("a_busy_after_start", a_busy, 1'b1);
    check("a_cs_after_start", a_spi_cs, 1'b0);
    wait_a_done(2000);
    exp_done_a++;
    check_frame_a("fixed");

    // ---- start held high while busy, plus a second pulse mid-frame ----
    tick(3);
    f0 = a_frames;
    @(negedge clk); start_a = 1'b1;
    repeat (300) @(negedge clk);
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    tick(1);
    wait_a_done(2000);
    exp_done_a++;
    check("held_one_frame", a_frames, f0 + 1);
    check_frame_a("held");
    // start raised in the done cycle is ignored; it is accepted one cycle later
    start_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start_a = 1'b0;
    #1;
    check("restart_cs_fall_delay", a_fall_cyc - a_done_cyc, 2);
    wait_a_done(2000);
    exp_done_a++;
    check_frame_a("restart");

    // ---- reset asserted mid-frame (word 2, bit 10) ----
    tick(3);
    pulse_a();
    n = 0;
    while (a_rises != 75 && n < 1000) begin tick(1); n++; end
    check("midrst_reached", a_rises, 75);
    check("midrst_widx", a_word_idx, 2);
    d0 = a_done_cnt;
    resetn = 1'b0;
    tick(1);
    check("midrst_cs", a_spi_cs, 1'b1);
    check("midrst_clk", a_spi_clk, 1'b0);
    check("midrst_busy", a_busy, 1'b0);
    check("midrst_mosi", a_spi_mosi, 1'b0);
    tick(2);
    resetn = 1'b1;
    tick(40);
    check("midrst_no_done", a_done_cnt, d0);
    for (int i = 0; i < A_WORDS; i++) ram_a[i] = $urandom;
    pulse_a();
    wait_a_done(2000);
    exp_done_a++;
    check_frame_a("after_rst");

    // ---- randomized frames on instance A ----
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < A_WORDS; i++) ram_a[i] = $urandom;
      tick($urandom_range(1, 12));
      pulse_a();
      wait_a_done(2000);
      exp_done_a++;
      check_frame_a($sformatf("rand%0d", k));
    end
    check("a_done_count", a_done_cnt, exp_done_a);

    // ---- instance B: CLK_DIV=1, alternating first word, then random ----
    ram_b[0] = 32'hAAAA_AAAA;
    for (int i = 1; i < B_WORDS; i++) ram_b[i] = $urandom;
    pulse_b();
    wait_b_done(6000);
    check_frame_b("b_alt");
    tick(2);
    for (int i = 0; i < B_WORDS; i++) ram_b[i] = $urandom;
    pulse_b();
    wait_b_done(6000);
    check_frame_b("b_rand");
    check("b_done_count", b_done_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
